// File: rtl/mem_dma_pkg.sv
// Shared definitions for the mem_dma copy/fill engine and the memory bus it
// shares with the cpu and memory models.
package mem_dma_pkg;

    localparam int AWIDTH = 30;
    localparam int DWIDTH = 32;

    localparam logic MODE_COPY = 1'b0;
    localparam logic MODE_FILL = 1'b1;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        WR   = 3'd2,
        FILL = 3'd3,
        DONE = 3'd4
    } state_t;

endpackage

// File: rtl/mem_dma.sv
// Word-granular bus-master copy/fill engine. Copy alternates RD/WR per word
// against a 1-cycle-latency memory; fill issues one write per word.
module mem_dma
    import mem_dma_pkg::*;
#(
    parameter int LWIDTH = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              mode,
    input  logic [AWIDTH-1:0] src,
    input  logic [AWIDTH-1:0] dst,
    input  logic [LWIDTH-1:0] len,
    input  logic [DWIDTH-1:0] pattern,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              mem_re,
    output logic              mem_we,
    output logic [AWIDTH-1:0] memaddr,
    input  logic [DWIDTH-1:0] rmemdata,
    output logic [DWIDTH-1:0] wmemdata
);

    state_t              r_state;
    state_t              w_next;
    logic [AWIDTH-1:0]   r_src;
    logic [AWIDTH-1:0]   r_dst;
    logic [LWIDTH-1:0]   r_cnt;
    logic                r_mode;
    logic [DWIDTH-1:0]   r_pattern;
    logic                w_last;

    assign w_last = (r_cnt == LWIDTH'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_src     <= '0;
            r_dst     <= '0;
            r_cnt     <= '0;
            r_mode    <= MODE_COPY;
            r_pattern <= '0;
        end else begin
            r_state <= w_next;
            unique case (r_state)
                IDLE: begin
                    if (start) begin
                        r_src     <= src;
                        r_dst     <= dst;
                        r_cnt     <= len;
                        r_mode    <= mode;
                        r_pattern <= pattern;
                    end
                end
                WR: begin
                    r_src <= r_src + AWIDTH'(1);
                    r_dst <= r_dst + AWIDTH'(1);
                    r_cnt <= r_cnt - LWIDTH'(1);
                end
                FILL: begin
                    r_dst <= r_dst + AWIDTH'(1);
                    r_cnt <= r_cnt - LWIDTH'(1);
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_next   = r_state;
        busy     = 1'b0;
        done     = 1'b0;
        mem_re   = 1'b0;
        mem_we   = 1'b0;
        memaddr  = '0;
        wmemdata = '0;
        unique case (r_state)
            IDLE: begin
                if (start) begin
                    if (len == '0)
                        w_next = DONE;
                    else if (mode == MODE_FILL)
                        w_next = FILL;
                    else
                        w_next = RD;
                end
            end
            RD: begin
                busy    = 1'b1;
                mem_re  = 1'b1;
                memaddr = r_src;
                w_next  = WR;
            end
            WR, FILL: begin
                // Copy forwards the memory's registered read word straight through.
                busy     = 1'b1;
                mem_we   = 1'b1;
                memaddr  = r_dst;
                wmemdata = (r_mode == MODE_FILL) ? r_pattern : rmemdata;
                if (w_last)
                    w_next = DONE;
                else if (r_state == WR)
                    w_next = RD;
                else
                    w_next = FILL;
            end
            DONE: begin
                done   = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
        // Abort beats completion: no done pulse even on the last word.
        if (busy && abort)
            w_next = IDLE;
    end

endmodule

// File: tb/tb_mem_dma.sv
// Scoreboard bench for mem_dma with a synchronous-read memory responder.
module tb_mem_dma;

    typedef struct packed {
        logic        re;
        logic        we;
        logic [29:0] addr;
        logic [31:0] data;
    } op_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        mode = 1'b0;
    logic        abort = 1'b0;
    logic [29:0] src = '0;
    logic [29:0] dst = '0;
    logic [15:0] len = '0;
    logic [31:0] pattern = '0;
    logic        busy, done, mem_re, mem_we;
    logic [29:0] memaddr;
    logic [31:0] rmemdata = '0;
    logic [31:0] wmemdata;

    logic [31:0] mem     [logic [29:0]];
    logic [31:0] ref_mem [logic [29:0]];
    op_t         q[$];
    int          checks = 0;
    int          errors = 0;
    int          done_cnt = 0;

    always #5 clk = ~clk;

    mem_dma #(.LWIDTH(16)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .src(src), .dst(dst),
        .len(len), .pattern(pattern), .abort(abort), .busy(busy), .done(done),
        .mem_re(mem_re), .mem_we(mem_we), .memaddr(memaddr),
        .rmemdata(rmemdata), .wmemdata(wmemdata)
    );

    // synchronous-read memory, 1-cycle latency
    always @(posedge clk) begin
        if (mem_re) rmemdata <= mem.exists(memaddr) ? mem[memaddr] : 32'h0;
        if (mem_we) mem[memaddr] = wmemdata;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        op_t got, exp;
        check("re_we_excl", 64'(mem_re & mem_we), 64'd0);
        if (!mem_re && !mem_we) check("addr_idle", 64'(memaddr), 64'd0);
        if (!mem_we) check("wdata_idle", 64'(wmemdata), 64'd0);
        if (mem_re || mem_we) begin
            got = '{re: mem_re, we: mem_we, addr: memaddr, data: wmemdata};
            exp = (q.size() > 0) ? q.pop_front() : op_t'('0);
            check("bus_op", 64'(got), 64'(exp));
        end
        if (done) done_cnt++;
    end

    function automatic logic [31:0] rd_ref(input logic [29:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
    endfunction

    function automatic logic [31:0] rd_mem(input logic [29:0] a);
        return mem.exists(a) ? mem[a] : 32'h0;
    endfunction

    task automatic preload(input logic [29:0] a, input logic [31:0] d);
        mem[a]     = d;
        ref_mem[a] = d;
    endtask

    // Push expected bus ops for the first nw words, then strobe start at edge T0.
    // Returns at T0+1ns. With hold, start stays high with a different command.
    task automatic issue(input logic m, input logic [29:0] s, input logic [29:0] d,
                         input logic [15:0] n, input logic [31:0] p, input bit hold,
                         input int nw);
        logic [29:0] sa, da;
        logic [31:0] dat;
        sa = s;
        da = d;
        for (int i = 0; i < nw; i++) begin
            if (m == 1'b0) begin
                dat = rd_ref(sa);
                q.push_back('{re: 1'b1, we: 1'b0, addr: sa, data: 32'h0});
            end else begin
                dat = p;
            end
            q.push_back('{re: 1'b0, we: 1'b1, addr: da, data: dat});
            ref_mem[da] = dat;
            sa = sa + 30'd1;
            da = da + 30'd1;
        end
        @(posedge clk); #1;
        mode = m; src = s; dst = d; len = n; pattern = p; start = 1'b1;
        @(posedge clk); #1;
        if (hold) begin
            dst = d + 30'h80; pattern = ~p; mode = ~m;
        end else begin
            start = 1'b0;
        end
    endtask

    task automatic wait_done(input string tag, input int exp_cyc);
        int cyc;
        bit seen;
        cyc = 0;
        seen = 1'b0;
        while (!seen && cyc < 200) begin
            @(negedge clk);
            cyc++;
            check({tag, "_busy"}, 64'(busy), 64'(cyc < exp_cyc));
            if (done) seen = 1'b1;
        end
        check({tag, "_done_cyc"}, 64'(cyc), 64'(exp_cyc));
    endtask

    task automatic end_test(input string tag, input int d0, input int exp_done);
        @(posedge clk); #1;
        check({tag, "_done_cnt"}, 64'(done_cnt - d0), 64'(exp_done));
        check({tag, "_sb_empty"}, 64'(q.size()), 64'd0);
    endtask

    initial begin
        int d0;
        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_re", 64'(mem_re), 64'd0);
        check("rst_we", 64'(mem_we), 64'd0);
        check("rst_addr", 64'(memaddr), 64'd0);
        check("rst_wdata", 64'(wmemdata), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // 1: copy 3 words
        preload(30'h10, 32'hA000_000A);
        preload(30'h11, 32'hB000_000B);
        preload(30'h12, 32'hC000_000C);
        d0 = done_cnt;
        issue(1'b0, 30'h10, 30'h20, 16'd3, 32'h0, 1'b0, 3);
        wait_done("copy", 7);
        end_test("copy", d0, 1);
        check("copy_m20", 64'(rd_mem(30'h20)), 64'hA000_000A);
        check("copy_m21", 64'(rd_mem(30'h21)), 64'hB000_000B);
        check("copy_m22", 64'(rd_mem(30'h22)), 64'hC000_000C);

        // 2: fill 4 words
        d0 = done_cnt;
        issue(1'b1, 30'h0, 30'h40, 16'd4, 32'hDEAD_BEEF, 1'b0, 4);
        wait_done("fill", 5);
        end_test("fill", d0, 1);
        for (int i = 0; i < 4; i++)
            check("fill_mem", 64'(rd_mem(30'h40 + 30'(i))), 64'hDEAD_BEEF);

        // 3: len = 0
        d0 = done_cnt;
        issue(1'b0, 30'h10, 30'h50, 16'd0, 32'h0, 1'b0, 0);
        wait_done("len0", 1);
        end_test("len0", d0, 1);

        // 4a: address wrap
        preload(30'h3FFF_FFFF, 32'h1111_2222);
        preload(30'h0, 32'h3333_4444);
        d0 = done_cnt;
        issue(1'b0, 30'h3FFF_FFFF, 30'h100, 16'd2, 32'h0, 1'b0, 2);
        wait_done("wrap", 5);
        end_test("wrap", d0, 1);
        check("wrap_m100", 64'(rd_mem(30'h100)), 64'h1111_2222);
        check("wrap_m101", 64'(rd_mem(30'h101)), 64'h3333_4444);

        // 4b: overlap dst = src+1 replicates the first word
        d0 = done_cnt;
        issue(1'b0, 30'h10, 30'h11, 16'd3, 32'h0, 1'b0, 3);
        wait_done("ovl", 7);
        end_test("ovl", d0, 1);
        for (int i = 1; i <= 3; i++)
            check("ovl_mem", 64'(rd_mem(30'h10 + 30'(i))), 64'hA000_000A);

        // 5: start held through busy and DONE with another command
        preload(30'h600, 32'h6000_0000);
        preload(30'h601, 32'h6000_0001);
        preload(30'h602, 32'h6000_0002);
        d0 = done_cnt;
        issue(1'b0, 30'h600, 30'h700, 16'd3, 32'h1234_5678, 1'b1, 3);
        wait_done("hold", 7);
        @(posedge clk); #1;
        start = 1'b0;
        end_test("hold", d0, 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("hold_idle_busy", 64'(busy), 64'd0);
        end
        check("hold_no_2nd", 64'(rd_mem(30'h780)), 64'd0);
        check("hold_m702", 64'(rd_mem(30'h702)), 64'h6000_0002);

        // 6a: abort at WR of word 2 of an 8-word copy
        for (int i = 0; i < 8; i++) begin
            preload(30'h200 + 30'(i), 32'h2000_0000 + 32'(i));
            preload(30'h300 + 30'(i), 32'h5A5A_0000 + 32'(i));
        end
        d0 = done_cnt;
        issue(1'b0, 30'h200, 30'h300, 16'd8, 32'h0, 1'b0, 2);
        repeat (3) @(posedge clk); #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        check("abt_busy", 64'(busy), 64'd0);
        check("abt_done", 64'(done), 64'd0);
        check("abt_we", 64'(mem_we), 64'd0);
        repeat (10) @(posedge clk); #1;
        check("abt_done_cnt", 64'(done_cnt - d0), 64'd0);
        check("abt_sb_empty", 64'(q.size()), 64'd0);
        check("abt_m301", 64'(rd_mem(30'h301)), 64'h2000_0001);
        for (int i = 2; i < 8; i++)
            check("abt_untouched", 64'(rd_mem(30'h300 + 30'(i))), 64'h5A5A_0000 + 64'(i));

        // 6b: same with rst
        for (int i = 0; i < 8; i++) begin
            preload(30'h400 + 30'(i), 32'h4000_0000 + 32'(i));
            preload(30'h500 + 30'(i), 32'hA5A5_0000 + 32'(i));
        end
        d0 = done_cnt;
        issue(1'b0, 30'h400, 30'h500, 16'd8, 32'h0, 1'b0, 2);
        repeat (3) @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("rst2_busy", 64'(busy), 64'd0);
        check("rst2_done", 64'(done), 64'd0);
        check("rst2_re", 64'(mem_re), 64'd0);
        check("rst2_we", 64'(mem_we), 64'd0);
        check("rst2_addr", 64'(memaddr), 64'd0);
        check("rst2_wdata", 64'(wmemdata), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (10) @(posedge clk); #1;
        check("rst2_done_cnt", 64'(done_cnt - d0), 64'd0);
        check("rst2_sb_empty", 64'(q.size()), 64'd0);
        for (int i = 2; i < 8; i++)
            check("rst2_untouched", 64'(rd_mem(30'h500 + 30'(i))), 64'hA5A5_0000 + 64'(i));

        // 7: abort on the last word beats done
        d0 = done_cnt;
        issue(1'b1, 30'h0, 30'h800, 16'd1, 32'hCAFE_F00D, 1'b0, 1);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        check("abtl_done", 64'(done), 64'd0);
        check("abtl_busy", 64'(busy), 64'd0);
        repeat (5) @(posedge clk); #1;
        check("abtl_done_cnt", 64'(done_cnt - d0), 64'd0);
        check("abtl_sb_empty", 64'(q.size()), 64'd0);
        check("abtl_m800", 64'(rd_mem(30'h800)), 64'hCAFE_F00D);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
